mimo_frame_loader: RTL

Parametrised MIMO front-end loader. Accepts a complex M×M channel matrix H and NY complex receive vectors Y, each of length M, as serial valid/ready streams. Once both are complete, it publishes H column-broadcast buses to the HQ/QR calculation stage and then streams the Y elements on consumer request. It sits between the sample-input interface and the QR decomposition datapath, and generalises the fixed 4×4 / 2-vector loader.

---
 rtl/mimo_frame_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mimo_frame_loader.sv
// MIMO frame loader: buffers an MxM complex H and NY complex Y vectors, then
// broadcasts H by column and streams Y. Option: MIMO_FRAME_LOADER_Y_CONJ_EN.
module mimo_frame_loader #(
  parameter int N  = 32,
  parameter int Q  = 22,
  parameter int M  = 4,
  parameter int NY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  H_in_valid,
  output logic                  H_in_ready,
  input  logic [N-1:0]          H_in_r,
  input  logic [N-1:0]          H_in_i,
  input  logic                  Y_in_valid,
  output logic                  Y_in_ready,
  input  logic [N-1:0]          Y_in_r,
  input  logic [N-1:0]          Y_in_i,
  input  logic                  g_valid,
  output logic                  start_hq_calc,
  output logic [2*M*M*N-1:0]    H_cols_r,
  output logic [2*M*M*N-1:0]    H_cols_i,
  output logic [NY*N-1:0]       y_out_r,
  output logic [NY*N-1:0]       y_out_i,
  output logic                  y_last,
  output logic                  ovf
);

  localparam int LM = $clog2(M);
  localparam int VW = (NY > 1) ? $clog2(NY) : 1;
  localparam logic [LM-1:0] KLAST = LM'(M - 1);
  localparam logic [VW-1:0] VLAST = VW'(NY - 1);

  // Q only travels with the samples; nothing here rescales.
  if (Q >= N) begin : g_q_wide
  end

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  state_t state, state_nx;

  logic [N-1:0]  h_mem_r [M][M];
  logic [N-1:0]  h_mem_i [M][M];
  logic [N-1:0]  hn_r    [M][M];
  logic [N-1:0]  hn_i    [M][M];
  logic [N-1:0]  y_mem_r [NY][M];
  logic [N-1:0]  y_mem_i [NY][M];
  logic [LM-1:0] h_row, h_col, y_idx, k;
  logic [VW-1:0] y_vec;
  logic          h_done, y_done;
  logic          h_acc, y_acc, h_fin, y_fin, load_done;
  logic [N-1:0]  y_wr_i;

`ifdef MIMO_FRAME_LOADER_Y_CONJ_EN
  assign y_wr_i = (Y_in_i == {1'b1, {(N-1){1'b0}}})
                ? {1'b0, {(N-1){1'b1}}} : -Y_in_i;
`else
  assign y_wr_i = Y_in_i;
`endif

  assign h_acc = H_in_valid && H_in_ready && !start;
  assign y_acc = Y_in_valid && Y_in_ready && !start;
  assign h_fin = h_done ||
                 (h_acc && h_row == KLAST && h_col == KLAST);
  assign y_fin = y_done ||
                 (y_acc && y_vec == VLAST && y_idx == KLAST);
  assign load_done = (state == LOAD) && h_fin && y_fin && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (start) state_nx = LOAD;
               else if (load_done) state_nx = STREAM;
      STREAM:  if (start) state_nx = LOAD;
               else if (g_valid && k == KLAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    H_in_ready = 1'b0;
    Y_in_ready = 1'b0;
    y_last     = 1'b0;
    y_out_r    = '0;
    y_out_i    = '0;
    if (state == LOAD) begin
      H_in_ready = !h_done;
      Y_in_ready = !y_done;
    end
    if (state == STREAM && g_valid) begin
      y_last = (k == KLAST);
      for (int v = 0; v < NY; v++) begin
        y_out_r[v*N +: N] = y_mem_r[v][k];
        y_out_i[v*N +: N] = y_mem_i[v][k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_row         <= '0;
      h_col         <= '0;
      y_vec         <= '0;
      y_idx         <= '0;
      h_done        <= 1'b0;
      y_done        <= 1'b0;
      ovf           <= 1'b0;
      k             <= '0;
      start_hq_calc <= 1'b0;
    end else begin
      start_hq_calc <= load_done;
      if (start) begin
        h_row  <= '0;
        h_col  <= '0;
        y_vec  <= '0;
        y_idx  <= '0;
        h_done <= 1'b0;
        y_done <= 1'b0;
        ovf    <= 1'b0;
        k      <= '0;
      end else begin
        if ((H_in_valid && !H_in_ready) ||
            (Y_in_valid && !Y_in_ready))
          ovf <= 1'b1;
        if (h_acc) begin
          h_col <= h_col + LM'(1);
          if (h_col == KLAST) h_row <= h_row + LM'(1);
          if (h_row == KLAST && h_col == KLAST) h_done <= 1'b1;
        end
        if (y_acc) begin
          y_idx <= y_idx + LM'(1);
          if (y_idx == KLAST) begin
            y_vec <= (y_vec == VLAST) ? '0 : y_vec + VW'(1);
            if (y_vec == VLAST) y_done <= 1'b1;
          end
        end
        if (load_done)
          k <= '0;
        else if (state == STREAM && g_valid)
          k <= k + LM'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (h_acc) begin
      h_mem_r[h_row][h_col] <= H_in_r;
      h_mem_i[h_row][h_col] <= H_in_i;
    end
    if (y_acc) begin
      y_mem_r[y_vec][y_idx] <= Y_in_r;
      y_mem_i[y_vec][y_idx] <= y_wr_i;
    end
  end

  // The completing H beat lands in h_mem on the same edge, so bypass it.
  always_comb begin
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < M; c++) begin
        hn_r[r][c] = h_mem_r[r][c];
        hn_i[r][c] = h_mem_i[r][c];
        if (h_acc && h_row == LM'(r) && h_col == LM'(c)) begin
          hn_r[r][c] = H_in_r;
          hn_i[r][c] = H_in_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      H_cols_r <= '0;
      H_cols_i <= '0;
    end else if (load_done) begin
      for (int c = 0; c < M; c++) begin
        for (int r = 0; r < M; r++) begin
          H_cols_r[(c*2*M + 2*r)*N     +: N] <= hn_r[r][c];
          H_cols_r[(c*2*M + 2*r + 1)*N +: N] <= hn_r[r][c];
          H_cols_i[(c*2*M + 2*r)*N     +: N] <= hn_i[r][c];
          H_cols_i[(c*2*M + 2*r + 1)*N +: N] <= hn_i[r][c];
        end
      end
    end
  end

endmodule
